pin_entry: RTL and testbench
============================

PIN_ENTRY -- requirements
Module: pin_entry

Interface
REQ-001 Parameter DEBOUNCE, default 250, is the number of consecutive stable synchronized cycles needed to accept a press or release.
REQ-002 Parameter DIGITS, default 4, is the PIN length in digits.
REQ-003 Port clk, input, 1 bit: the single clock; all logic SHALL be rising-edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-low reset.
REQ-005 Port key_raw, input, 1 bit: keypad strobe, asynchronous and bouncing.
REQ-006 Port key_code, input, 4 bits: 0-9 is a digit, 10 is CLEAR, 11 is ENTER, 12-15 are illegal; it is stable while key_raw is high.
REQ-007 Port pin_out, output, 4*DIGITS bits: the PIN in BCD, with the first-entered digit in the most significant nibble.
REQ-008 Port pin_valid, output, 1 bit: pin_out holds a complete PIN.
REQ-009 Port pin_ready, input, 1 bit: the consumer accepts the PIN.
REQ-010 Port digit_count, output, $clog2(DIGITS+1) bits: the number of digits held.
REQ-011 Port entry_err, output, 1 bit: a one-cycle error pulse.

Function
REQ-012 key_raw SHALL pass through a 2-flop synchronizer before debounce.
REQ-013 A press SHALL qualify on the cycle the synchronized key_raw has been 1 for DEBOUNCE consecutive cycles, and exactly once per press.
REQ-014 Re-arm SHALL require the synchronized key_raw to be 0 for DEBOUNCE consecutive cycles; a glitch of fewer cycles SHALL restart the count.
REQ-015 key_code SHALL be captured on the qualification cycle, and the resulting action SHALL be visible on outputs the next cycle.
REQ-016 The FSM SHALL have four states: IDLE, COLLECT, FULL and PRESENT.
REQ-017 A digit in IDLE or COLLECT SHALL shift into the buffer and increment digit_count; the next state is FULL when the count reaches DIGITS, otherwise COLLECT.
REQ-018 A digit in FULL SHALL be dropped, pulse entry_err, and leave the buffer and count unchanged.
REQ-019 CLEAR in IDLE, COLLECT or FULL SHALL zero the buffer and count, go to IDLE, and raise no error.
REQ-020 ENTER in FULL SHALL go to PRESENT, with pin_valid=1 the next cycle.
REQ-021 ENTER in IDLE or COLLECT SHALL pulse entry_err, zero the buffer and count, and go to IDLE.
REQ-022 An illegal code (12-15) in IDLE, COLLECT or FULL SHALL pulse entry_err with no other change.
REQ-023 In PRESENT, pin_out and pin_valid SHALL hold until a rising edge with pin_ready=1.
REQ-024 On that edge, the next cycle SHALL have pin_valid=0, pin_out=0, digit_count=0 and state IDLE.
REQ-025 Keys qualifying in PRESENT SHALL be ignored silently.
REQ-026 A key qualifying on the same edge as the pin_ready handshake SHALL be ignored.
REQ-027 pin_out SHALL be 0 whenever the state is not PRESENT.
REQ-028 pin_valid SHALL be 1 only in PRESENT.
REQ-029 entry_err SHALL never be high for two consecutive cycles from a single press.

Reset
REQ-030 reset=0 at a rising edge SHALL force the state to IDLE, pin_out=0, pin_valid=0, digit_count=0 and entry_err=0.
REQ-031 reset=0 at a rising edge SHALL clear the synchronizer flops and both debounce counters, and set the debounce to the re-armed, released condition.
REQ-032 Reset asserted mid-press, mid-entry or in PRESENT SHALL discard all partial state.
REQ-033 A key held through reset release SHALL need a full DEBOUNCE high period after release before it qualifies.

Structure
REQ-034 Package pin_entry_pkg SHALL hold the state enum and the key-code constants KEY_CLEAR=10 and KEY_ENTER=11.
REQ-035 Synchronizer and debounce SHALL live in sub-module key_debounce, parameterized by DEBOUNCE and producing a one-cycle press_pulse.
REQ-036 Buffer, count and FSM SHALL live in pin_entry; counter widths SHALL be derived with $clog2.

Verification (DEBOUNCE=4, DIGITS=4)
REQ-037 Press 1,2,3,4, then ENTER, with pin_ready=0 -> pin_valid=1 and pin_out=16'h1234, held for 20 cycles; raise pin_ready -> next cycle pin_valid=0, pin_out=0, digit_count=0.
REQ-038 Press 1,2,3, then ENTER -> entry_err one-cycle pulse, digit_count=0, pin_valid stays 0.
REQ-039 Bounce key_raw 1-0-1-0 with 2-cycle highs before a stable hold -> exactly one digit accepted, digit_count=1.
REQ-040 Enter 4 digits, then digit 9 -> entry_err pulse, pin_out after ENTER = 16'h1234 (the 9 is dropped); CLEAR after 2 digits -> digit_count=0, no error.
REQ-041 Drive reset=0 for one cycle after 3 digits, then press 5,6,7,8 and ENTER -> pin_out=16'h5678.
REQ-042 Random key_raw toggling and random reset for 1000 cycles -> pin_valid never 1 outside PRESENT, entry_err never high 2 cycles consecutively, digit_count never exceeds 4.

Source files
------------

// File: rtl/pin_entry_pkg.sv
// pin_entry shared types and key codes.
// Imported by the PIN entry FSM.
package pin_entry_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    FULL,
    PRESENT
  } state_t;

  localparam logic [3:0] KEY_CLEAR = 4'd10;
  localparam logic [3:0] KEY_ENTER = 4'd11;

  function automatic logic is_digit(input logic [3:0] c);
    return c <= 4'd9;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Keypad strobe synchronizer and debounce.
// Emits one press_pulse per stable press.
module key_debounce #(
  parameter int DEBOUNCE = 250
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw,
  output logic press_pulse
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);

  logic          s1;
  logic          s2;
  logic          armed;
  logic [CW-1:0] hi_cnt;
  logic [CW-1:0] lo_cnt;

  // the press fires on the DEBOUNCE-th consecutive high sample
  assign press_pulse = armed && s2 && (hi_cnt == LAST);

  // two-flop synchronizer for the asynchronous strobe
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= key_raw;
      s2 <= s1;
    end
  end

  // count stable highs while armed, stable lows while disarmed
  always_ff @(posedge clk) begin
    if (!reset) begin
      hi_cnt <= '0;
      lo_cnt <= '0;
      armed  <= 1'b1;
    end else if (armed) begin
      lo_cnt <= '0;
      if (!s2) begin
        hi_cnt <= '0;
      end else if (hi_cnt == LAST) begin
        hi_cnt <= '0;
        armed  <= 1'b0;
      end else begin
        hi_cnt <= hi_cnt + CW'(1);
      end
    end else begin
      hi_cnt <= '0;
      if (s2) begin
        lo_cnt <= '0;
      end else if (lo_cnt == LAST) begin
        lo_cnt <= '0;
        armed  <= 1'b1;
      end else begin
        lo_cnt <= lo_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/pin_entry.sv
// PIN entry: debounced keypad into a BCD buffer,
// presented to a consumer with a valid/ready handshake.
module pin_entry
  import pin_entry_pkg::*;
#(
  parameter int DEBOUNCE = 250,
  parameter int DIGITS   = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       key_raw,
  input  logic [3:0]                 key_code,
  output logic [4*DIGITS-1:0]        pin_out,
  output logic                       pin_valid,
  input  logic                       pin_ready,
  output logic [$clog2(DIGITS+1)-1:0] digit_count,
  output logic                       entry_err
);

  localparam int PW = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DIGITS);

  state_t        state_q, state_n;
  logic [PW-1:0] pin_q, pin_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic          err_q, err_n;
  logic          press;
  logic          k_dig, k_clr, k_ent;

  key_debounce #(
    .DEBOUNCE(DEBOUNCE)
  ) u_deb (
    .clk        (clk),
    .reset      (reset),
    .key_raw    (key_raw),
    .press_pulse(press)
  );

  assign k_dig = is_digit(key_code);
  assign k_clr = key_code == KEY_CLEAR;
  assign k_ent = key_code == KEY_ENTER;

  assign pin_out     = (state_q == PRESENT) ? pin_q : '0;
  assign pin_valid   = state_q == PRESENT;
  assign digit_count = cnt_q;
  assign entry_err   = err_q;

  // state, buffer, count and error registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      pin_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      pin_q   <= pin_n;
      cnt_q   <= cnt_n;
      err_q   <= err_n;
    end
  end

  // next state: handshake in PRESENT, key actions elsewhere
  always_comb begin
    state_n = state_q;
    pin_n   = pin_q;
    cnt_n   = cnt_q;
    err_n   = 1'b0;
    unique case (state_q)
      PRESENT: begin
        if (pin_ready) begin
          state_n = IDLE;
          pin_n   = '0;
          cnt_n   = '0;
        end
      end
      IDLE, COLLECT, FULL: begin
        if (press) begin
          unique case (1'b1)
            k_dig: begin
              if (state_q == FULL) begin
                err_n = 1'b1;
              end else begin
                pin_n   = (pin_q << 4) | PW'(key_code);
                cnt_n   = cnt_q + CW'(1);
                state_n = (cnt_n == FULL_CNT) ? FULL : COLLECT;
              end
            end
            k_clr: begin
              pin_n   = '0;
              cnt_n   = '0;
              state_n = IDLE;
            end
            k_ent: begin
              if (state_q == FULL) begin
                state_n = PRESENT;
              end else begin
                err_n   = 1'b1;
                pin_n   = '0;
                cnt_n   = '0;
                state_n = IDLE;
              end
            end
            default: err_n = 1'b1;
          endcase
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pin_entry.sv
// Bench for pin_entry: directed key sequences plus
// random keying against a behavioural reference model.
module tb_pin_entry;

  localparam int D = 4;
  localparam int N = 4;

  logic        clk;
  logic        reset;
  logic        key_raw;
  logic [3:0]  key_code;
  logic [15:0] pin_out;
  logic        pin_valid;
  logic        pin_ready;
  logic [2:0]  digit_count;
  logic        entry_err;

  int total = 0;
  int bad   = 0;
  int err_seen = 0;
  bit chk_en = 0;
  bit prev_err = 0;

  pin_entry #(
    .DEBOUNCE(D),
    .DIGITS  (N)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .key_raw    (key_raw),
    .key_code   (key_code),
    .pin_out    (pin_out),
    .pin_valid  (pin_valid),
    .pin_ready  (pin_ready),
    .digit_count(digit_count),
    .entry_err  (entry_err)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // reference model: synced history window, digit queue
  bit r1, r2, syn, m_armed, qual, all1, all0;
  bit hist[$];
  int dq[$];
  bit m_pres, m_err;

  function automatic logic [31:0] m_pin();
    logic [31:0] v = 0;
    foreach (dq[i]) v = v * 16 + dq[i];
    return v;
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      r1 = 0; r2 = 0; m_armed = 1;
      hist.delete(); dq.delete();
      m_pres = 0; m_err = 0;
    end else begin
      syn = r2; r2 = r1; r1 = key_raw;
      hist.push_back(syn);
      if (hist.size() > D) void'(hist.pop_front());
      all1 = 0; all0 = 0;
      if (hist.size() == D) begin
        all1 = 1; all0 = 1;
        foreach (hist[i]) begin
          if (hist[i]) all0 = 0;
          else all1 = 0;
        end
      end
      qual = 0;
      if (m_armed && all1) begin
        qual = 1; m_armed = 0;
      end else if (!m_armed && all0) begin
        m_armed = 1;
      end
      m_err = 0;
      if (m_pres) begin
        if (pin_ready) begin
          m_pres = 0; dq.delete();
        end
      end else if (qual) begin
        if (key_code <= 9) begin
          if (dq.size() == N) m_err = 1;
          else dq.push_back(int'(key_code));
        end else if (key_code == 10) begin
          dq.delete();
        end else if (key_code == 11) begin
          if (dq.size() == N) m_pres = 1;
          else begin m_err = 1; dq.delete(); end
        end else begin
          m_err = 1;
        end
      end
    end
  end

  // compare DUT with the model every cycle, away from the edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid", 32'(pin_valid), 32'(m_pres));
      chk("pin", 32'(pin_out), m_pres ? m_pin() : 32'd0);
      chk("count", 32'(digit_count), 32'(dq.size()));
      chk("err", 32'(entry_err), 32'(m_err));
      chk("err2", 32'(entry_err & prev_err), 32'd0);
      chk("cmax", 32'(digit_count > 3'd4), 32'd0);
      if (entry_err) err_seen++;
      prev_err = entry_err;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic hold(input bit v, input int n);
    key_raw = v;
    cyc(n);
  endtask

  task automatic press(input int c);
    key_code = 4'(c);
    hold(1, D + 4);
    hold(0, D + 4);
  endtask

  task automatic handshake();
    pin_ready = 1;
    cyc(1);
    pin_ready = 0;
  endtask

  int e0;
  int seg;

  initial begin
    reset = 0; key_raw = 0; key_code = 0; pin_ready = 0;
    cyc(2);
    chk_en = 1;
    chk("rst_valid", 32'(pin_valid), 0);
    chk("rst_pin", 32'(pin_out), 0);
    chk("rst_cnt", 32'(digit_count), 0);
    chk("rst_err", 32'(entry_err), 0);
    reset = 1;
    cyc(2);

    // full PIN, held while not ready, then accepted
    press(1); press(2); press(3); press(4);
    chk("d4_cnt", 32'(digit_count), 4);
    press(11);
    chk("p_valid", 32'(pin_valid), 1);
    chk("p_pin", 32'(pin_out), 32'h1234);
    cyc(20);
    chk("p_hold_v", 32'(pin_valid), 1);
    chk("p_hold_p", 32'(pin_out), 32'h1234);
    handshake();
    chk("hs_valid", 32'(pin_valid), 0);
    chk("hs_pin", 32'(pin_out), 0);
    chk("hs_cnt", 32'(digit_count), 0);

    // short PIN then ENTER
    press(1); press(2); press(3);
    e0 = err_seen;
    press(11);
    chk("short_err", 32'(err_seen - e0), 1);
    chk("short_cnt", 32'(digit_count), 0);
    chk("short_v", 32'(pin_valid), 0);

    // bounce before a stable hold
    key_code = 4'd7;
    hold(1, 2); hold(0, 2); hold(1, 2); hold(0, 2);
    hold(1, D + 4); hold(0, D + 4);
    chk("bounce_cnt", 32'(digit_count), 1);
    press(10);

    // fifth digit dropped
    press(1); press(2); press(3); press(4);
    e0 = err_seen;
    press(9);
    chk("over_err", 32'(err_seen - e0), 1);
    chk("over_cnt", 32'(digit_count), 4);
    press(11);
    chk("over_pin", 32'(pin_out), 32'h1234);
    handshake();

    // clear mid-entry
    press(3); press(5);
    e0 = err_seen;
    press(10);
    chk("clr_cnt", 32'(digit_count), 0);
    chk("clr_err", 32'(err_seen - e0), 0);

    // illegal code
    press(2);
    e0 = err_seen;
    press(13);
    chk("ill_err", 32'(err_seen - e0), 1);
    chk("ill_cnt", 32'(digit_count), 1);
    press(10);

    // reset mid-entry discards digits
    press(1); press(2); press(3);
    reset = 0;
    cyc(1);
    reset = 1;
    chk("mrst_cnt", 32'(digit_count), 0);
    press(5); press(6); press(7); press(8); press(11);
    chk("mrst_pin", 32'(pin_out), 32'h5678);
    handshake();

    // random keying, ready and reset
    seg = 0;
    while (seg < 1000) begin
      int len;
      len = $urandom_range(1, 10);
      if (!key_raw) key_code = ($urandom_range(0, 9) < 7) ?
        4'($urandom_range(0, 9)) : 4'($urandom_range(10, 15));
      key_raw = ~key_raw;
      pin_ready = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 59) == 0) begin
        reset = 0;
        cyc(1);
        reset = 1;
        seg += 1;
      end
      cyc(len);
      seg += len;
    end
    key_raw = 0;
    pin_ready = 0;
    cyc(D + 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
